i2c_txn_sequencer: RTL
======================

# i2c_txn_sequencer

Upstream command stage for the I2C master FSM. Buffers host-written bytes in a small FIFO and turns each transaction (address byte, data bytes, end marker) into the FSM's `start`/`stop`/`data_in` stimulus. Consumes the FSM's `busy`/`done`/`ack_in` and aborts cleanly on NACK. Exposes an `idle` flag so the I2C clock domain can be gated for low power.

## Interface
- `FIFO_DEPTH`, 4: command FIFO entries; power of two, ≥2.
- `clk` in 1: system clock.
- `reset_n` in 1: asynchronous, active-low reset.
- `wr_valid` in 1: host byte valid.
- `wr_ready` out 1: FIFO not full.
- `wr_data` in 8: byte; the first byte of a transaction is the address (7-bit address + R/W).
- `wr_last` in 1: marks the final byte of a transaction.
- `start` out 1: one-cycle pulse that launches one byte transfer on the FSM.
- `stop` out 1: one-cycle pulse that requests a STOP condition.
- `data_in` out 8: byte for the FSM; held stable from the `start` pulse until `done`.
- `ack_in` in 1: slave acknowledge, 1 = ACK; sampled only in the `done` cycle.
- `busy` in 1: FSM busy.
- `done` in 1: FSM one-cycle completion pulse, for a byte or for a STOP.
- `txn_done` out 1: one-cycle pulse when a transaction ends with all bytes ACKed.
- `txn_nack` out 1: one-cycle pulse when a transaction is aborted by NACK.
- `tx_bytes` out 8: number of ACKed bytes in the last finished transaction; saturates at 255.
- `idle` out 1: high when state is IDLE and the FIFO is empty.

## Operation
- FIFO: 9-bit entries {last, data}. Write when `wr_valid & wr_ready`. `wr_ready = !full` and is registered-state only, with no combinational path from pop. A simultaneous push and pop leaves the count unchanged.
- States:
  - IDLE: if FIFO non-empty, pop into `data_in`, set `last_r`, clear the byte counter, and go to ISSUE.
  - ISSUE: assert `start` for 1 cycle, then go to WAIT.
  - WAIT: wait for `done`.
    - `done & ack_in & !last_r`: increment the counter and go to LOAD.
    - `done & ack_in & last_r`: increment the counter and go to STOP.
    - `done & !ack_in`: set `nack_r`, then go to STOP if `last_r`, else to FLUSH.
  - LOAD: if FIFO non-empty, pop into `data_in`/`last_r` and go to ISSUE. Otherwise stay in LOAD, holding the bus with no timeout.
  - FLUSH: pop one entry per cycle while non-empty. When the popped entry has last = 1, go to STOP. While empty, wait.
  - STOP: assert `stop` for 1 cycle, then go to STOP_WAIT.
  - STOP_WAIT: on `done`, load `tx_bytes` from the counter. Pulse `txn_nack` if `nack_r`, else `txn_done`, in the following cycle. Clear `nack_r` and go to IDLE.
- `busy` is informational only. A `done` outside WAIT or STOP_WAIT is ignored.
- A transaction of a single entry (address with last = 1) is legal: address, then STOP.
- Reset values: `start`=0, `stop`=0, `data_in`=0, `txn_done`=0, `txn_nack`=0, `tx_bytes`=0, `idle`=1, `wr_ready`=1. FIFO is empty and state is IDLE.
- Reset asserted mid-transaction clears everything immediately, including FIFO contents. No STOP is generated; the FSM is reset by the same `reset_n`.

## Timing
- Host write accepted at cycle N into an empty FIFO while IDLE: pop at N+1, `start` at N+2 with `data_in` valid.
- `done` at cycle D with ACK and the next byte already queued: pop at D+1, `start` at D+2.
- `done` at cycle D on the last byte: `stop` at D+1.
- STOP `done` at cycle S: `txn_done`/`txn_nack` and the updated `tx_bytes` visible at S+1. `idle` is high at S+1 if the FIFO is empty.
- `start` and `stop` are never high in the same cycle. Each is a one-cycle pulse.
- Back-to-back transactions: IDLE at S+1 may pop immediately, so the next `start` is at S+2.

## Test plan
- Reset, then write 0xAA (last = 0) and 0xCC (last = 1); model ACKs both → `start` pulses with `data_in` = 0xAA then 0xCC, `stop` once, `txn_done` = 1, `tx_bytes` = 2.
- Write 0xF0, 0x0F, 0x55 (last on 0x55); model NACKs 0xF0 → FLUSH drops 0x0F and 0x55 with no `start` for them, `stop` issued, `txn_nack` = 1, `tx_bytes` = 0, FIFO empty.
- Fill the FIFO with 4 bytes while the FSM holds `busy` → `wr_ready` = 0 after the 4th accept. Pops resume and `wr_ready` = 1 one cycle after the first pop.
- Write the address only (last = 0) and withhold data for 20 cycles → sequencer stays in LOAD, no `stop`. Writing 0x11 (last = 1) then produces `start` 2 cycles later.
- Assert `reset_n` = 0 while in WAIT → all outputs return to reset values immediately, `idle` = 1. After release, no spurious `start`.
- Send two back-to-back single-address transactions (0xA0 last, 0xA2 last) → the second `start` occurs exactly 1 cycle after the first `txn_done` pulse.

Source files
------------

// File: rtl/i2c_txn_sequencer_if.sv
// Bundles the host write port, the byte-level I2C FSM handshake and the
// transaction status outputs of the command sequencer.
interface i2c_txn_sequencer_if;
   logic       wr_valid;
   logic       wr_ready;
   logic [7:0] wr_data;
   logic       wr_last;
   logic       start;
   logic       stop;
   logic [7:0] data_in;
   logic       ack_in;
   logic       busy;
   logic       done;
   logic       txn_done;
   logic       txn_nack;
   logic [7:0] tx_bytes;
   logic       idle;

   // Sequencer side.
   modport slave (
      input  wr_valid, wr_data, wr_last, ack_in, busy, done,
      output wr_ready, start, stop, data_in, txn_done, txn_nack, tx_bytes, idle
   );

   // Host and I2C byte FSM side.
   modport master (
      output wr_valid, wr_data, wr_last, ack_in, busy, done,
      input  wr_ready, start, stop, data_in, txn_done, txn_nack, tx_bytes, idle
   );
endinterface

// File: rtl/i2c_txn_sequencer.sv
// Command sequencer in front of the I2C byte FSM: queues host bytes and turns
// each {address, data..., last} transaction into start/stop pulses, aborting
// the rest of a transaction when the slave NACKs.
//
// state       | meaning
// ------------|-----------------------------------------------------------
// S_IDLE      | no transaction open; pops the address byte when queued
// S_ISSUE     | start pulse high for the byte held in data_in
// S_WAIT      | byte transfer in flight, waiting for done/ack
// S_LOAD      | byte ACKed, waiting (indefinitely) for the next queued byte
// S_FLUSH     | NACK seen; discarding queued bytes up to the last marker
// S_STOP      | stop pulse high
// S_STOP_WAIT | STOP in flight; reports the transaction result on done
module i2c_txn_sequencer #(
   parameter int FIFO_DEPTH = 4
) (
   input logic           clk,
   input logic           reset_n,
   i2c_txn_sequencer_if.slave bus
);
   localparam int AW = $clog2(FIFO_DEPTH);
   localparam logic [AW:0] FULL_CNT = FIFO_DEPTH[AW:0];

   typedef enum logic [2:0] {
      S_IDLE, S_ISSUE, S_WAIT, S_LOAD, S_FLUSH, S_STOP, S_STOP_WAIT
   } state_t;

   state_t        state;
   logic [8:0]    mem [FIFO_DEPTH];
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic [AW:0]   count;
   logic [8:0]    head;
   logic          empty;
   logic          push;
   logic          pop;

   logic          start_r;
   logic          stop_r;
   logic [7:0]    data_r;
   logic          last_r;
   logic          nack_r;
   logic [7:0]    byte_cnt;
   logic          txn_done_r;
   logic          txn_nack_r;
   logic [7:0]    tx_bytes_r;

   // busy is informational only; completion is taken from done.
   logic unused_busy;
   assign unused_busy = bus.busy;

   // wr_ready derives from the registered count only, never from this cycle's pop.
   assign empty        = (count == '0);
   assign bus.wr_ready = (count != FULL_CNT);
   assign push         = bus.wr_valid & bus.wr_ready;
   assign pop          = !empty && (state == S_IDLE || state == S_LOAD || state == S_FLUSH);
   assign head         = mem[rd_ptr];

   assign bus.start    = start_r;
   assign bus.stop     = stop_r;
   assign bus.data_in  = data_r;
   assign bus.txn_done = txn_done_r;
   assign bus.txn_nack = txn_nack_r;
   assign bus.tx_bytes = tx_bytes_r;
   assign bus.idle     = (state == S_IDLE) && empty;

   // FIFO storage; contents are don't-care once pointers are reset.
   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr] <= {bus.wr_last, bus.wr_data};
   end

   // FIFO pointers and occupancy; push and pop together leave the count unchanged.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (pop)  rd_ptr <= rd_ptr + 1'b1;
         case ({push, pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   // Transaction FSM with registered pulse outputs.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state      <= S_IDLE;
         start_r    <= 1'b0;
         stop_r     <= 1'b0;
         data_r     <= 8'h00;
         last_r     <= 1'b0;
         nack_r     <= 1'b0;
         byte_cnt   <= 8'h00;
         txn_done_r <= 1'b0;
         txn_nack_r <= 1'b0;
         tx_bytes_r <= 8'h00;
      end else begin
         start_r    <= 1'b0;
         stop_r     <= 1'b0;
         txn_done_r <= 1'b0;
         txn_nack_r <= 1'b0;
         case (state)
            S_IDLE: begin
               if (!empty) begin
                  data_r   <= head[7:0];
                  last_r   <= head[8];
                  byte_cnt <= 8'h00;
                  start_r  <= 1'b1;
                  state    <= S_ISSUE;
               end
            end
            S_ISSUE: state <= S_WAIT;
            S_WAIT: begin
               if (bus.done) begin
                  if (bus.ack_in) begin
                     if (byte_cnt != 8'hFF) byte_cnt <= byte_cnt + 8'd1;
                  end else begin
                     nack_r <= 1'b1;
                  end
                  if (last_r) begin
                     stop_r <= 1'b1;
                     state  <= S_STOP;
                  end else if (bus.ack_in) begin
                     state <= S_LOAD;
                  end else begin
                     state <= S_FLUSH;
                  end
               end
            end
            S_LOAD: begin
               if (!empty) begin
                  data_r  <= head[7:0];
                  last_r  <= head[8];
                  start_r <= 1'b1;
                  state   <= S_ISSUE;
               end
            end
            S_FLUSH: begin
               if (!empty && head[8]) begin
                  stop_r <= 1'b1;
                  state  <= S_STOP;
               end
            end
            S_STOP: state <= S_STOP_WAIT;
            S_STOP_WAIT: begin
               if (bus.done) begin
                  tx_bytes_r <= byte_cnt;
                  txn_nack_r <= nack_r;
                  txn_done_r <= !nack_r;
                  nack_r     <= 1'b0;
                  state      <= S_IDLE;
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end
endmodule
